toy_mc_eu_wrapper: RTL and testbench

TOY_MC_EU_WRAPPER -- requirements
Module: toy_mc_eu_wrapper

---
 rtl/toy_mc_eu_wrapper.sv | 135 +++++++++++++
 tb/tb_toy_mc_eu_wrapper.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_mc_eu_wrapper.sv
// Issue wrapper for a fixed-latency execution unit: credit-limited admission,
// an in-flight valid pipe, and an in-order result FIFO with flush.
module toy_mc_eu_wrapper #(
  parameter int PLD_W     = 128,
  parameter int RES_W     = 160,
  parameter int LATENCY   = 4,
  parameter int DEPTH     = 4,
  parameter int PIPELINED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [PLD_W-1:0] in_pld,
  input  logic [31:0]      in_csr,
  input  logic             flush,
  output logic             eu_vld,
  output logic [PLD_W-1:0] eu_pld,
  output logic [31:0]      eu_csr,
  input  logic [RES_W-1:0] eu_res,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [RES_W-1:0] out_res,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  logic               accept;
  logic               pop;
  logic               tap;
  logic               fifo_wr;
  logic               eu_vld_q;
  logic [PLD_W-1:0]   eu_pld_q;
  logic [31:0]        eu_csr_q;
  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [RES_W-1:0]   mem_q [2**PTR_W];

  // Occupancy is a credit count covering both the pipe and the FIFO, so a
  // result leaving the pipe always has a free FIFO slot waiting for it.
  assign in_rdy  = !flush && (occ_q < CNT_MAX) && ((PIPELINED != 0) || (occ_q == '0));
  assign accept  = in_vld && in_rdy;
  assign tap     = pipe_q[LATENCY-1];
  assign fifo_wr = tap && !flush;
  assign out_vld = (cnt_q != '0);
  assign pop     = out_vld && out_rdy;
  assign out_res = mem_q[rd_ptr_q];
  assign busy    = (occ_q != '0);
  assign eu_vld  = eu_vld_q;
  assign eu_pld  = eu_pld_q;
  assign eu_csr  = eu_csr_q;

  // Pipe bit 0 rises together with eu_vld; the tap marks the cycle in which
  // eu_res is sampled (the LATENCY-th cycle, counting the eu_vld cycle as 1).
  generate
    if (LATENCY == 1) begin : g_pipe_one
      assign pipe_d = accept;
    end else begin : g_pipe_shift
      assign pipe_d = {pipe_q[LATENCY-2:0], accept};
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({fifo_wr, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eu_vld_q <= 1'b0;
      eu_pld_q <= '0;
      eu_csr_q <= '0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      eu_vld_q <= accept;
      if (accept) begin
        eu_pld_q <= in_pld;
        eu_csr_q <= in_csr;
      end
      if (flush) begin
        pipe_q   <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        occ_q    <= '0;
      end else begin
        pipe_q   <= pipe_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        occ_q    <= occ_d;
      end
    end
  end

  // Result storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= eu_res;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && (cnt_q == CNT_MAX) && !pop));

endmodule

// File: tb/tb_toy_mc_eu_wrapper.sv
// Bench for toy_mc_eu_wrapper: directed vector table, multi-cycle sequences,
// and random traffic against a queue-based reference model.
module tb_toy_mc_eu_wrapper;

  localparam int PW = 128;
  localparam int RW = 160;
  localparam int L  = 4;
  localparam int D  = 4;

  typedef struct packed {
    logic iv, ordy, fl, e_rdy, e_euv, e_ov, e_busy;
  } vec_t;

  typedef struct {
    int            rdy;
    logic [RW-1:0] val;
  } item_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld, in_vld_b, flush, out_rdy, out_rdy_b;
  logic [PW-1:0] in_pld;
  logic [31:0]   in_csr;
  logic [RW-1:0] eu_res, eu_res_b;
  logic          in_rdy, eu_vld, out_vld, busy;
  logic [PW-1:0] eu_pld;
  logic [31:0]   eu_csr;
  logic [RW-1:0] out_res;
  logic          in_rdy_b, eu_vld_b, out_vld_b, busy_b;
  logic [PW-1:0] eu_pld_b;
  logic [31:0]   eu_csr_b;
  logic [RW-1:0] out_res_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int dut_acc = 0;
  int dut_acc_b = 0;

  item_t mq[$];
  item_t mqb[$];
  logic          last_acc, last_acc_b;
  logic [PW-1:0] last_pld, last_pld_b;
  logic [31:0]   last_csr, last_csr_b;
  logic [RW-1:0] pa [64];
  logic [RW-1:0] pb [64];
  bit            pa_v [64];
  bit            pb_v [64];
  logic          s_in_rdy, s_eu_vld, s_out_vld, s_busy, s_in_rdy_b, s_out_vld_b;
  vec_t          tab [16];

  always #5 clk = ~clk;

  toy_mc_eu_wrapper #(.PLD_W(PW), .RES_W(RW), .LATENCY(L), .DEPTH(D), .PIPELINED(1)) u_dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_pld(in_pld),
    .in_csr(in_csr), .flush(flush), .eu_vld(eu_vld), .eu_pld(eu_pld),
    .eu_csr(eu_csr), .eu_res(eu_res), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_res(out_res), .busy(busy));

  toy_mc_eu_wrapper #(.PLD_W(PW), .RES_W(RW), .LATENCY(L), .DEPTH(1), .PIPELINED(0)) u_blk (
    .clk(clk), .rst(rst), .in_vld(in_vld_b), .in_rdy(in_rdy_b), .in_pld(in_pld),
    .in_csr(in_csr), .flush(flush), .eu_vld(eu_vld_b), .eu_pld(eu_pld_b),
    .eu_csr(eu_csr_b), .eu_res(eu_res_b), .out_vld(out_vld_b), .out_rdy(out_rdy_b),
    .out_res(out_res_b), .busy(busy_b));

  function automatic logic [RW-1:0] iu(input logic [31:0] c, input logic [PW-1:0] p);
    return {c ^ 32'hA5A5_5A5A, ~p};
  endfunction

  function automatic logic [RW-1:0] junk();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    mq.delete();
    mqb.delete();
    last_acc = 1'b0;  last_acc_b = 1'b0;
    last_pld = '0;    last_pld_b = '0;
    last_csr = '0;    last_csr_b = '0;
  endtask

  // Called at posedge+1 with this cycle's inputs applied; ends at next posedge+1.
  task automatic tick();
    int  i;
    logic e_rdy, e_ov, e_rdyb, e_ovb, acc, pop;
    i = cyc % 64;
    // Inner-unit stand-ins: the result of an issue is presented in its L-th cycle.
    if (eu_vld)   begin pa_v[(cyc+L-1)%64] = 1'b1; pa[(cyc+L-1)%64] = iu(eu_csr, eu_pld); end
    if (eu_vld_b) begin pb_v[(cyc+L-1)%64] = 1'b1; pb[(cyc+L-1)%64] = iu(eu_csr_b, eu_pld_b); end
    eu_res   = pa_v[i] ? pa[i] : junk();
    eu_res_b = pb_v[i] ? pb[i] : junk();
    pa_v[i] = 1'b0;
    pb_v[i] = 1'b0;
    #1;
    e_rdy  = !flush && (mq.size() < D);
    e_ov   = (mq.size() != 0) && (mq[0].rdy <= cyc);
    e_rdyb = !flush && (mqb.size() == 0);
    e_ovb  = (mqb.size() != 0) && (mqb[0].rdy <= cyc);
    s_in_rdy = in_rdy;  s_eu_vld = eu_vld;  s_out_vld = out_vld;  s_busy = busy;
    s_in_rdy_b = in_rdy_b;  s_out_vld_b = out_vld_b;
    chk1("in_rdy",  in_rdy,  e_rdy);
    chk1("out_vld", out_vld, e_ov);
    chk1("busy",    busy,    mq.size() != 0);
    chk1("eu_vld",  eu_vld,  last_acc);
    chkw("eu_pld",  RW'(eu_pld), RW'(last_pld));
    chkw("eu_csr",  RW'(eu_csr), RW'(last_csr));
    if (e_ov) chkw("out_res", out_res, mq[0].val);
    chk1("b_in_rdy",  in_rdy_b,  e_rdyb);
    chk1("b_out_vld", out_vld_b, e_ovb);
    chk1("b_busy",    busy_b,    mqb.size() != 0);
    chk1("b_eu_vld",  eu_vld_b,  last_acc_b);
    chkw("b_eu_pld",  RW'(eu_pld_b), RW'(last_pld_b));
    if (e_ovb) chkw("b_out_res", out_res_b, mqb[0].val);
    if (in_vld && in_rdy)     dut_acc++;
    if (in_vld_b && in_rdy_b) dut_acc_b++;
    @(posedge clk);
    acc = in_vld && e_rdy;
    pop = e_ov && out_rdy;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{cyc + L + 1, iu(in_csr, in_pld)});
    end
    last_acc = acc;
    if (acc) begin last_pld = in_pld; last_csr = in_csr; end
    acc = in_vld_b && e_rdyb;
    pop = e_ovb && out_rdy_b;
    if (flush) mqb.delete();
    else begin
      if (pop) void'(mqb.pop_front());
      if (acc) mqb.push_back('{cyc + L + 1, iu(in_csr, in_pld)});
    end
    last_acc_b = acc;
    if (acc) last_pld_b = in_pld;
    cyc++;
    #1;
  endtask

  task automatic new_pld();
    in_pld = {$urandom, $urandom, $urandom, $urandom};
    in_csr = $urandom;
  endtask

  task automatic idle();
    in_vld = 1'b0; in_vld_b = 1'b0; out_rdy = 1'b1; out_rdy_b = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk1("rst_eu_vld",  eu_vld,  1'b0);
    chk1("rst_out_vld", out_vld, 1'b0);
    chk1("rst_busy",    busy,    1'b0);
    chkw("rst_eu_pld",  RW'(eu_pld), '0);
    chk1("rst_b_out_vld", out_vld_b, 1'b0);
    chk1("rst_b_busy",    busy_b,    1'b0);
    clear_model();
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    // iv ordy fl | rdy euv ov busy : single issue, then flush with work in pipe and FIFO
    tab[0]  = 7'b110_1000;  tab[1]  = 7'b010_1101;  tab[2]  = 7'b010_1001;
    tab[3]  = 7'b010_1001;  tab[4]  = 7'b010_1001;  tab[5]  = 7'b010_1011;
    tab[6]  = 7'b010_1000;
    tab[7]  = 7'b100_1000;  tab[8]  = 7'b000_1101;  tab[9]  = 7'b100_1001;
    tab[10] = 7'b100_1101;  tab[11] = 7'b000_1101;  tab[12] = 7'b001_0011;
    tab[13] = 7'b000_1000;  tab[14] = 7'b000_1000;  tab[15] = 7'b000_1000;

    for (int k = 0; k < 64; k++) begin pa_v[k] = 1'b0; pb_v[k] = 1'b0; end
    rst = 1'b1; in_vld = 1'b0; in_vld_b = 1'b0; flush = 1'b0;
    out_rdy = 1'b0; out_rdy_b = 1'b0; in_pld = '0; in_csr = '0;
    eu_res = '0; eu_res_b = '0;
    clear_model();
    #3;
    chk1("por_eu_vld",  eu_vld,  1'b0);
    chk1("por_out_vld", out_vld, 1'b0);
    chk1("por_busy",    busy,    1'b0);
    chkw("por_eu_csr",  RW'(eu_csr), '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk1("por_in_rdy", in_rdy, 1'b1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 7) idle();
      in_vld = tab[i].iv; out_rdy = tab[i].ordy; flush = tab[i].fl;
      new_pld();
      tick();
      chk1("tab_in_rdy",  s_in_rdy,  tab[i].e_rdy);
      chk1("tab_eu_vld",  s_eu_vld,  tab[i].e_euv);
      chk1("tab_out_vld", s_out_vld, tab[i].e_ov);
      chk1("tab_busy",    s_busy,    tab[i].e_busy);
    end

    // Six back-to-back requests into a stalled consumer
    idle();
    base = dut_acc;
    in_vld = 1'b1; out_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      new_pld();
      tick();
      if (k == 4) chk1("fill_rdy_low", s_in_rdy, 1'b0);
    end
    chki("fill_acc4", dut_acc - base, 4);
    out_rdy = 1'b1;
    for (int k = 0; k < 40 && (dut_acc - base) < 6; k++) begin new_pld(); tick(); end
    in_vld = 1'b0;
    chki("fill_acc6", dut_acc - base, 6);
    repeat (12) tick();

    // Accept and pop together at occupancy DEPTH-1
    idle();
    out_rdy = 1'b0; in_vld = 1'b1;
    repeat (3) begin new_pld(); tick(); end
    in_vld = 1'b0;
    repeat (3) tick();
    in_vld = 1'b1; out_rdy = 1'b1; new_pld();
    tick();
    chk1("ap_rdy_a", s_in_rdy,  1'b1);
    chk1("ap_ov_a",  s_out_vld, 1'b1);
    in_vld = 1'b0; out_rdy = 1'b0;
    tick();
    chk1("ap_rdy_b",  s_in_rdy, 1'b1);
    chk1("ap_euv_b",  s_eu_vld, 1'b1);
    out_rdy = 1'b1;
    repeat (10) tick();

    // Non-pipelined, single-entry instance blocks until its result is popped
    idle();
    base = dut_acc_b;
    in_vld_b = 1'b1; out_rdy_b = 1'b0;
    for (int k = 0; k < 9; k++) begin
      new_pld();
      tick();
      if (k == 3) chk1("blk_rdy_c3", s_in_rdy_b, 1'b0);
      if (k == 5) chk1("blk_ov_c5",  s_out_vld_b, 1'b1);
      if (k == 8) chk1("blk_rdy_c8", s_in_rdy_b, 1'b0);
    end
    out_rdy_b = 1'b1;
    tick();
    new_pld();
    tick();
    chk1("blk_rdy_c10", s_in_rdy_b, 1'b1);
    in_vld_b = 1'b0;
    chki("blk_acc", dut_acc_b - base, 2);
    repeat (8) tick();

    // Reset pulse while one instruction is in flight
    idle();
    in_vld = 1'b1; new_pld();
    tick();
    in_vld = 1'b0;
    tick();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 6) chk1("rst_no_result", s_out_vld, 1'b0);
    end

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      in_vld    = ($urandom % 4) != 0;
      in_vld_b  = ($urandom % 3) != 0;
      out_rdy   = ($urandom % 3) != 0;
      out_rdy_b = ($urandom % 2) != 0;
      flush     = ($urandom % 40) == 0;
      new_pld();
      tick();
    end
    idle();
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
